// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI command decoder and register bank (sclk domain).
// Takes framed bytes from the slave shift stage and runs burst
// writes/reads over 2**ADDR_W byte registers. The top slot is a
// read-only ID register.
//
// Ports:
//   sclk, rst      clock; asynchronous active-high reset
//   cs             active-low frame qualifier
//   rx_valid       one-cycle strobe, rx_data holds a received byte
//   rx_data        received byte
//   err_clr        synchronous clear of err_flag
//   tx_data        byte for the next transmit slot
//   tx_load        one-cycle strobe, tx_data newly valid
//   wr_strobe      one-cycle pulse, a register write happened
//   wr_addr        address of the last write
//   reg_flat       all registers, reg i at [8i+7:8i]
//   err_flag       sticky protocol-error flag
module spi_reg_bank #(
    parameter int         ADDR_W = 4,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     err_clr,
    output logic [7:0]               tx_data,
    output logic                     tx_load,
    output logic                     wr_strobe,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [8*(2**ADDR_W)-1:0] reg_flat,
    output logic                     err_flag
);

    localparam int                N        = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP      = '1;
    // Command bits between the read flag and the address field.
    localparam logic [7:0]        RSV_MASK = 8'h7F & ~8'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD,
        ERR
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [7:0]        regs [N];
    logic [ADDR_W-1:0] ptr;
    logic              rd_pend;
    logic [7:0]        rd_val;

    logic              take;
    logic              cmd_ok;
    logic              cmd_bad;
    logic              wr_go;
    logic              rd_go;

    assign take   = rx_valid & ~cs;
    assign rd_val = (ptr == TOP) ? ID_VAL : regs[ptr];

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        cmd_ok  = 1'b0;
        cmd_bad = 1'b0;
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        if (cs) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                // A byte arriving on the very first cs-low edge is
                // already the command, so IDLE decodes like CMD.
                IDLE, CMD: begin
                    state_n = CMD;
                    if (take) begin
                        if ((rx_data & RSV_MASK) != 8'h00) begin
                            cmd_bad = 1'b1;
                            state_n = ERR;
                        end else begin
                            cmd_ok  = 1'b1;
                            state_n = rx_data[7] ? RD : WR;
                        end
                    end
                end
                WR:      wr_go = take;
                RD:      rd_go = take;
                ERR:     state_n = ERR;
                default: state_n = IDLE;
            endcase
        end
    end

    // Reads are fetched one edge after the byte that requests them, so
    // the fetch sees any write made earlier in the frame.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            rd_pend   <= 1'b0;
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err_flag  <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;
            rd_pend   <= (cmd_ok & rx_data[7]) | rd_go;
            err_flag  <= cmd_bad | (err_flag & ~err_clr);
            if (rd_pend && !cs) begin
                tx_data <= rd_val;
                tx_load <= 1'b1;
            end
            if (cmd_ok) begin
                ptr <= rx_data[ADDR_W-1:0];
            end else if (wr_go || rd_go) begin
                ptr <= ptr + ADDR_W'(1);
            end
            if (wr_go) begin
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
            end
        end
    end

    // The top slot is never written; it reads back as ID_VAL.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_go && ptr != TOP) begin
            regs[ptr] <= rx_data;
        end
    end

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < N - 1; i++) begin
            reg_flat[8*i +: 8] = regs[i];
        end
        reg_flat[8*(N-1) +: 8] = ID_VAL;
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed bench for spi_reg_bank with a byte-level
// protocol model and a per-cycle compare process.
module tb_spi_reg_bank;

    logic         sclk;
    logic         rst;
    logic         cs;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         err_clr;
    logic [7:0]   tx_data;
    logic         tx_load;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic [127:0] reg_flat;
    logic         err_flag;

    spi_reg_bank #(.ADDR_W(4), .ID_VAL(8'hA5)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cs        (cs),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .err_clr   (err_clr),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .reg_flat  (reg_flat),
        .err_flag  (err_flag)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    bit run    = 0;

    // Byte-level model: frame position, mode, pointer, register image.
    localparam int M_WR  = 0;
    localparam int M_RD  = 1;
    localparam int M_ERR = 2;

    logic [7:0] m_regs [16];
    bit         m_first;
    int         m_mode;
    logic [3:0] m_ptr;
    bit         m_err;
    logic [3:0] m_waddr;
    logic [7:0] m_tx;
    logic [7:0] exp_tx [int];
    logic [3:0] exp_wr [int];
    logic [7:0] got_tx [$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    function automatic logic [7:0] mval(logic [3:0] p);
        return (p == 4'hF) ? 8'hA5 : m_regs[p];
    endfunction

    function automatic logic [127:0] mflat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = mval(4'(i));
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_first = 1; m_mode = M_WR; m_ptr = 0; m_err = 0;
        m_waddr = 0; m_tx = 0;
        exp_tx.delete();
        exp_wr.delete();
    endtask

    // One sampling edge as seen by the protocol rules; c is the cycle
    // count at the negedge before that edge.
    task automatic model_edge(bit v, logic [7:0] b, bit clr, bit cs_v, int c);
        bit bad = 0;
        if (cs_v) begin
            m_first = 1;
        end else if (v) begin
            if (m_first) begin
                m_first = 0;
                if ((b & 8'h70) != 0) begin
                    bad = 1;
                    m_mode = M_ERR;
                end else begin
                    m_ptr  = b[3:0];
                    m_mode = b[7] ? M_RD : M_WR;
                    if (b[7]) exp_tx[c + 2] = mval(m_ptr);
                end
            end else if (m_mode == M_WR) begin
                if (m_ptr != 4'hF) m_regs[m_ptr] = b;
                exp_wr[c + 1] = m_ptr;
                m_waddr = m_ptr;
                m_ptr++;
            end else if (m_mode == M_RD) begin
                m_ptr++;
                exp_tx[c + 2] = mval(m_ptr);
            end
        end
        m_err = bad | (m_err & !clr);
    endtask

    always @(posedge sclk) cyc++;

    always @(negedge sclk) begin
        if (run) begin
            if (exp_tx.exists(cyc)) m_tx = exp_tx[cyc];
            chk("tx_load", {127'b0, tx_load}, {127'b0, exp_tx.exists(cyc)});
            chk("tx_data", {120'b0, tx_data}, {120'b0, m_tx});
            if (tx_load) got_tx.push_back(tx_data);
            chk("wr_strobe", {127'b0, wr_strobe},
                {127'b0, exp_wr.exists(cyc)});
            if (wr_strobe) wr_cnt++;
            chk("wr_addr", {124'b0, wr_addr}, {124'b0, m_waddr});
            chk("reg_flat", reg_flat, mflat());
            chk("err_flag", {127'b0, err_flag}, {127'b0, m_err});
        end
    end

    // Drives one byte at the current negedge; returns at the next one.
    task automatic drive_byte(logic [7:0] b, bit clr);
        int c = cyc;
        rx_valid = 1; rx_data = b; err_clr = clr;
        @(posedge sclk);
        model_edge(1, b, clr, cs, c);
        @(negedge sclk);
        rx_valid = 0; rx_data = 8'h00; err_clr = 0;
    endtask

    task automatic send(logic [7:0] b, bit clr = 0);
        @(negedge sclk);
        drive_byte(b, clr);
    endtask

    task automatic idle_edge(bit clr);
        int c;
        @(negedge sclk);
        c = cyc;
        err_clr = clr;
        @(posedge sclk);
        model_edge(0, 8'h00, clr, cs, c);
        @(negedge sclk);
        err_clr = 0;
    endtask

    task automatic cs_low();
        @(negedge sclk);
        cs = 0;
    endtask

    task automatic cs_high();
        @(negedge sclk);
        cs = 1;
        idle_edge(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; cs = 1; rx_valid = 0; rx_data = 0; err_clr = 0;
        model_reset();
        repeat (2) @(negedge sclk);
        chk("rst reg_flat", reg_flat, {8'hA5, 120'h0});
        chk("rst tx_data", {120'b0, tx_data}, 128'h0);
        chk("rst flags", {125'b0, tx_load, wr_strobe, err_flag}, 128'h0);
        chk("rst wr_addr", {124'b0, wr_addr}, 128'h0);
        rst = 0;
        run = 1;

        // Burst write.
        wr_cnt = 0;
        cs_low();
        send(8'h02); send(8'h11); send(8'h22); send(8'h33);
        cs_high();
        chk("bw reg2", {120'b0, reg_flat[23:16]}, 128'h11);
        chk("bw reg3", {120'b0, reg_flat[31:24]}, 128'h22);
        chk("bw reg4", {120'b0, reg_flat[39:32]}, 128'h33);
        chk("bw strobes", 128'(wr_cnt), 128'd3);
        chk("bw wr_addr", {124'b0, wr_addr}, 128'h4);

        // Preload with a write that wraps over the ID slot.
        cs_low();
        send(8'h0E); send(8'h3C); send(8'h00); send(8'h5D);
        cs_high();
        chk("wrap reg14", {120'b0, reg_flat[119:112]}, 128'h3C);
        chk("wrap reg0", {120'b0, reg_flat[7:0]}, 128'h5D);

        // Burst read with wrap.
        got_tx.delete();
        cs_low();
        send(8'h8E); send(8'hFF); send(8'h00);
        idle_edge(0);
        cs_high();
        chk("rd count", 128'(got_tx.size()), 128'd3);
        chk("rd byte0", {120'b0, got_tx.size() > 0 ? got_tx[0] : 8'hxx}, 128'h3C);
        chk("rd byte1", {120'b0, got_tx.size() > 1 ? got_tx[1] : 8'hxx}, 128'hA5);
        chk("rd byte2", {120'b0, got_tx.size() > 2 ? got_tx[2] : 8'hxx}, 128'h5D);

        // ID protect.
        cs_low();
        send(8'h0F); send(8'h5A);
        chk("id wr_addr", {124'b0, wr_addr}, 128'hF);
        cs_high();
        chk("id reg15", {120'b0, reg_flat[127:120]}, 128'hA5);
        chk("id err", {127'b0, err_flag}, 128'h0);

        // Reserved bits, clear, and set-beats-clear.
        cs_low();
        send(8'h30); send(8'h77);
        chk("rsv err", {127'b0, err_flag}, 128'h1);
        cs_high();
        idle_edge(1);
        chk("clr err", {127'b0, err_flag}, 128'h0);
        cs_low();
        send(8'h40, 1);
        chk("set wins", {127'b0, err_flag}, 128'h1);
        cs_high();

        // Abort, then a frame whose first byte lands on the cs edge.
        cs_low();
        send(8'h05); send(8'hAA);
        cs_high();
        @(negedge sclk);
        cs = 0;
        drive_byte(8'h06, 0);
        send(8'hBB);
        cs_high();
        chk("abort reg5", {120'b0, reg_flat[47:40]}, 128'hAA);
        chk("abort reg6", {120'b0, reg_flat[55:48]}, 128'hBB);
        send(8'h07); send(8'h99);
        chk("cs1 ignored reg7", {120'b0, reg_flat[63:56]}, 128'h00);

        // Reset in the middle of a burst.
        cs_low();
        send(8'h01); send(8'h12);
        #2;
        rst = 1; cs = 1;
        model_reset();
        #1;
        chk("mid rst reg_flat", reg_flat, {8'hA5, 120'h0});
        chk("mid rst tx_data", {120'b0, tx_data}, 128'h0);
        chk("mid rst flags", {125'b0, tx_load, wr_strobe, err_flag}, 128'h0);
        chk("mid rst wr_addr", {124'b0, wr_addr}, 128'h0);
        @(negedge sclk);
        rst = 0;
        cs_low();
        send(8'h03); send(8'h44);
        cs_high();
        chk("post rst flat", reg_flat, {8'hA5, 88'h0, 8'h44, 24'h0});

        repeat (2) @(negedge sclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register-bank command decoder sitting directly downstream of the SPI slave shift stage, in the sclk domain.
- Consumes received bytes framed by cs and interprets them as a command byte followed by data bytes.
- Supports burst write and burst read with address auto-increment.
- Drives the next transmit byte back to the shift stage for read-out, and exposes all registers as a flat bus to the core.

Parameters:
- ADDR_W, 4, address width; register count = 2**ADDR_W.
- ID_VAL, 8'hA5, constant returned by the top address (read-only ID register).

Ports:
- sclk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- cs  input  1  chip select, active-low frame qualifier.
- rx_valid  input  1  one-cycle strobe; rx_data holds a complete received byte.
- rx_data  input  8  received byte.
- err_clr  input  1  synchronous clear of err_flag.
- tx_data  output  8  byte for the shift stage to transmit in the next byte slot.
- tx_load  output  1  one-cycle strobe; tx_data newly valid.
- wr_strobe  output  1  one-cycle pulse; a register was written this cycle.
- wr_addr  output  ADDR_W  address of the last write.
- reg_flat  output  8*2**ADDR_W  all registers; reg i at bits [8i+7:8i]; top slot = ID_VAL.
- err_flag  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, any state): all writable registers 0; tx_data 0; tx_load 0; wr_strobe 0; wr_addr 0; err_flag 0; address pointer 0; state IDLE.
- rx_valid is acted on only when cs=0 at the same edge. rx_valid with cs=1 is ignored.
- A cs=1 sample at any edge forces state IDLE. Any in-progress burst is aborted; already-written bytes are kept.
- States:
  - IDLE: when cs=0 go to CMD. If rx_valid is also high at that edge, it is treated as the command byte (decoded as in CMD).
  - CMD: on rx_valid, decode the command byte.
    - bit7: 1 = read, 0 = write.
    - bits[6:ADDR_W] reserved; any set bit -> go to ERR, set err_flag.
    - bits[ADDR_W-1:0]: start address loaded into the pointer.
    - Write -> go to WR.
    - Read -> go to RD; tx_data <= reg[start] and tx_load=1 on the following edge (one-cycle latency).
  - WR: each rx_valid writes rx_data to reg[ptr]; wr_strobe=1, wr_addr=ptr for exactly that next cycle; ptr increments.
    - Write to the top address: register unchanged, wr_strobe still pulses, no error.
  - RD: each rx_valid (dummy byte, content ignored) increments ptr; tx_data <= reg[ptr+1] and tx_load=1 one cycle later.
  - ERR: all rx_valid ignored until cs=1.
- Pointer wraps from 2**ADDR_W-1 to 0 (modulo arithmetic, no error).
- reg_flat reflects a write on the cycle after the sampling edge, i.e. registered.
- err_flag: set on reserved-bit violation; cleared by err_clr; if set and clear occur at the same edge, set wins.
- tx_load and wr_strobe never stay high for two consecutive cycles from a single byte.
- Reads in the same frame return values written earlier in that frame.

Test Plan:
- Burst write: cs=0, bytes 0x02,0x11,0x22,0x33 -> reg2=0x11, reg3=0x22, reg4=0x33; three wr_strobe pulses with wr_addr 2,3,4; err_flag 0.
- Burst read with wrap: regs preloaded, frame 0x8E then two dummy bytes -> tx_load pulses with tx_data = reg14, ID_VAL (0xA5), reg0.
- ID protect: frame 0x0F,0x5A -> reg15 still reads 0xA5; wr_strobe pulses with wr_addr=15; err_flag 0.
- Reserved bits: frame 0x30,0x77 -> err_flag=1, no register changes; err_clr pulse -> err_flag=0; err_clr coincident with new violation -> err_flag stays 1.
- Abort/reframe: frame 0x05,0xAA, cs high, new frame 0x06,0xBB -> reg5=0xAA, reg6=0xBB; second frame's first byte decoded as command. rx_valid with cs=1 -> no effect.
- Reset mid-burst: assert rst between data bytes -> all outputs and registers zero immediately (ID still 0xA5); next frame starts in CMD.
